// File: rtl/poly_pkg.sv
// Shared definitions for the Horner polynomial sequencer.
//   - default WIDTH / MAX_DEG
//   - state encoding for the sequencer FSM
//   - degree-port and index width helpers
package poly_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_MAX_DEG = 3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD_COEF = 3'd1,
      S_LOAD_X    = 3'd2,
      S_MUL       = 3'd3,
      S_ADD       = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   // Degree port width. One code wider than the largest legal degree so an
   // out-of-range request (e.g. deg=MAX_DEG+1) is representable and can be
   // flagged instead of silently aliasing onto a legal degree.
   function automatic int deg_w(input int max_deg);
      return ($clog2(max_deg + 2) < 1) ? 1 : $clog2(max_deg + 2);
   endfunction

   // Width of the coefficient index (0..MAX_DEG).
   function automatic int idx_w(input int max_deg);
      return ($clog2(max_deg + 1) < 1) ? 1 : $clog2(max_deg + 1);
   endfunction

endpackage

// File: rtl/poly_alu.sv
// Combinational add/multiply unit shared by every Horner step.
//   a, b     : operands
//   op       : 0 = add, 1 = multiply
//   y        : result modulo 2^WIDTH
//   ovf_bit  : carry out (add) or nonzero upper product half (mul)
module poly_alu #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] y,
   output logic             ovf_bit
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     sum;

   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign sum  = {1'b0, a} + {1'b0, b};

   always_comb begin
      y       = sum[WIDTH-1:0];
      ovf_bit = sum[WIDTH];
      if (op) begin
         y       = prod[WIDTH-1:0];
         ovf_bit = |prod[2*WIDTH-1:WIDTH];
      end
   end

endmodule

// File: rtl/horner_sequencer.sv
// Multi-cycle Horner evaluator: loads deg+1 coefficients (highest order
// first) and then x over a valid/ready stream, alternates MUL/ADD steps on a
// single poly_alu, and presents the result on a valid/ready output.
//   clk, reset           : clock, synchronous active-high reset
//   start, deg           : request an evaluation of degree deg (IDLE only)
//   in_valid/in_ready    : input handshake, in_data = coefficient or x
//   out_valid/out_ready  : result handshake, out_data = result mod 2^WIDTH
//   ovf                  : sticky overflow over the current evaluation
//   busy                 : not idle
//   err                  : one-cycle pulse on start with deg > MAX_DEG
module horner_sequencer
   import poly_pkg::*;
#(
   parameter  int WIDTH   = DEF_WIDTH,
   parameter  int MAX_DEG = DEF_MAX_DEG,
   localparam int DEG_W   = deg_w(MAX_DEG),
   localparam int IDX_W   = idx_w(MAX_DEG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DEG_W-1:0] deg,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             ovf,
   output logic             busy,
   output logic             err
);

   state_t state, state_nxt;

   logic [MAX_DEG:0][WIDTH-1:0] coef;
   logic [WIDTH-1:0]            acc;
   logic [WIDTH-1:0]            x;
   logic [IDX_W-1:0]            idx;
   logic [IDX_W-1:0]            idx_m1;
   logic [IDX_W-1:0]            deg_q;
   logic                        ovf_acc;
   logic                        err_q;
   logic                        deg_bad;

   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_y;
   logic             alu_op;
   logic             alu_ovf;

   assign idx_m1  = idx - IDX_W'(1);
   assign deg_bad = deg > DEG_W'(MAX_DEG);

   // MUL: acc*x ; ADD: acc+coef[idx-1]
   assign alu_op = (state == S_MUL);
   assign alu_b  = alu_op ? x : coef[idx_m1];

   poly_alu #(.WIDTH(WIDTH)) u_alu (
      .a       (acc),
      .b       (alu_b),
      .op      (alu_op),
      .y       (alu_y),
      .ovf_bit (alu_ovf)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:      if (start && !deg_bad)         state_nxt = S_LOAD_COEF;
         S_LOAD_COEF: if (in_valid && idx == '0)     state_nxt = S_LOAD_X;
         S_LOAD_X:    if (in_valid)                  state_nxt = (deg_q == '0) ? S_DONE : S_MUL;
         S_MUL:                                      state_nxt = S_ADD;
         S_ADD:                                      state_nxt = (idx_m1 == '0) ? S_DONE : S_MUL;
         S_DONE:      if (out_ready)                 state_nxt = S_IDLE;
         default:                                    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         coef    <= '0;
         acc     <= '0;
         x       <= '0;
         idx     <= '0;
         deg_q   <= '0;
         ovf_acc <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state)
            S_IDLE: if (start) begin
               if (deg_bad) begin
                  err_q <= 1'b1;
               end else begin
                  deg_q   <= deg[IDX_W-1:0];
                  idx     <= deg[IDX_W-1:0];
                  ovf_acc <= 1'b0;
               end
            end
            S_LOAD_COEF: if (in_valid) begin
               coef[idx] <= in_data;
               idx       <= idx_m1;
            end
            S_LOAD_X: if (in_valid) begin
               x   <= in_data;
               acc <= coef[deg_q];
               idx <= deg_q;
            end
            S_MUL: begin
               acc     <= alu_y;
               ovf_acc <= ovf_acc | alu_ovf;
            end
            S_ADD: begin
               acc     <= alu_y;
               ovf_acc <= ovf_acc | alu_ovf;
               idx     <= idx_m1;
            end
            default: ;
         endcase
      end
   end

   // All outputs come from registers or the state decode only.
   assign in_ready  = (state == S_LOAD_COEF) || (state == S_LOAD_X);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign out_data  = acc;
   assign ovf       = ovf_acc;
   assign err       = err_q;

endmodule

// File: tb/tb_horner_sequencer.sv
// Directed bench for horner_sequencer (WIDTH=8, MAX_DEG=3).
module tb_horner_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] deg;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       ovf;
   logic       busy;
   logic       err;

   int n_checks = 0;
   int n_errors = 0;

   horner_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .deg       (deg),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .ovf       (ovf),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] w, input int gap);
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
   endtask

   // c[d] is the highest-order coefficient; c[0] is the constant term.
   // Loads, waits for out_valid and returns the cycles counted after the x edge.
   task automatic load_and_wait(input string tag, input int d, input logic [3:0][7:0] c,
                                input logic [7:0] xv, input int max_gap, output int lat,
                                output logic busy_ok);
      start = 1'b1;
      deg   = 3'(d);
      tick();
      start = 1'b0;
      busy_ok = busy;
      for (int i = d; i >= 0; i--) send(c[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
      send(xv, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         busy_ok = busy_ok & busy;
         tick();
         lat++;
      end
      busy_ok = busy_ok & busy;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
   endtask

   task automatic transfer(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_xfer_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_xfer_busy"},  32'(busy),      32'd0);
   endtask

   int   lat;
   logic bok;
   logic stable;
   logic [7:0] held;

   initial begin
      reset = 1'b1; start = 1'b0; deg = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);
      chk("rst_err",       32'(err),       32'd0);
      tick();

      // basic: 1,2,3,4 at x=2 -> 26
      load_and_wait("basic", 3, {8'd1, 8'd2, 8'd3, 8'd4}, 8'd2, 0, lat, bok);
      chk("basic_lat",  32'(lat),      32'd6);
      chk("basic_data", 32'(out_data), 32'd26);
      chk("basic_ovf",  32'(ovf),      32'd0);
      chk("basic_busy", 32'(bok),      32'd1);
      transfer("basic");

      // degree 0, back-to-back in the first IDLE cycle
      load_and_wait("deg0", 0, {8'd0, 8'd0, 8'd0, 8'd7}, 8'd99, 0, lat, bok);
      chk("deg0_lat",  32'(lat),      32'd0);
      chk("deg0_data", 32'(out_data), 32'd7);
      chk("deg0_ovf",  32'(ovf),      32'd0);
      transfer("deg0");

      // overflow: 16x^2 at x=16 -> 4096 mod 256 = 0
      load_and_wait("ovf", 2, {8'd0, 8'd16, 8'd0, 8'd0}, 8'd16, 0, lat, bok);
      chk("ovf_lat",  32'(lat),      32'd4);
      chk("ovf_data", 32'(out_data), 32'd0);
      chk("ovf_flag", 32'(ovf),      32'd1);
      transfer("ovf");

      // flag is per evaluation: x+1 at x=1 -> 2
      load_and_wait("clr", 1, {8'd0, 8'd0, 8'd1, 8'd1}, 8'd1, 0, lat, bok);
      chk("clr_data", 32'(out_data), 32'd2);
      chk("clr_ovf",  32'(ovf),      32'd0);
      transfer("clr");

      // input gaps, then output back-pressure with ignored start pulses
      load_and_wait("gap", 3, {8'd1, 8'd2, 8'd3, 8'd4}, 8'd2, 3, lat, bok);
      chk("gap_lat",  32'(lat),      32'd6);
      chk("gap_data", 32'(out_data), 32'd26);
      held   = out_data;
      stable = 1'b1;
      deg    = 3'd1;
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         tick();
         stable = stable & out_valid & (out_data == held) & busy;
      end
      chk("bp_stable", 32'(stable), 32'd1);
      start = 1'b1;
      transfer("bp");
      start = 1'b0;
      tick();
      chk("bp_start_ignored", 32'(busy), 32'd0);

      // reset in the middle of MUL
      start = 1'b1; deg = 3'd1;
      tick();
      start = 1'b0;
      send(8'd3, 0); send(8'd5, 0); send(8'd2, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_out_data",  32'(out_data),  32'd0);
      chk("mrst_busy",      32'(busy),      32'd0);
      chk("mrst_in_ready",  32'(in_ready),  32'd0);
      chk("mrst_ovf",       32'(ovf),       32'd0);
      load_and_wait("post", 1, {8'd0, 8'd0, 8'd3, 8'd5}, 8'd2, 0, lat, bok);
      chk("post_lat",  32'(lat),      32'd2);
      chk("post_data", 32'(out_data), 32'd11);
      transfer("post");

      // illegal degree
      start = 1'b1; deg = 3'd4;
      tick();
      start = 1'b0;
      chk("err_pulse",    32'(err),      32'd1);
      chk("err_busy",     32'(busy),     32'd0);
      chk("err_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("err_clear",    32'(err),      32'd0);
      chk("err_idle",     32'(busy),     32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
